// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_pkg
//  Description : Shared types and constants for the MEM/WB pipeline slice.
//                Holds the data-memory access FSM state type, the datapath
//                and register-index widths, and a byte sign-extend helper.
//  Revision    : 1.0  initial release
// ============================================================================
package mips_pkg;

    localparam int unsigned c_DATA_W = 32;
    localparam int unsigned c_REG_W  = 5;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } mem_state_t;

    // Pick one byte lane out of a word and sign-extend it to full width.
    function automatic logic [c_DATA_W-1:0] sext_byte(
        input logic [c_DATA_W-1:0] word,
        input logic [1:0]          lane
    );
        logic [7:0] b;
        b = word[8*lane +: 8];
        return {{(c_DATA_W-8){b[7]}}, b};
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_wb_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_wb_stage_if
//  Description : EX/MEM -> MEM/WB bundle for the memory stage.
//                master : upstream pipeline (drives EX/MEM fields, sees
//                         write-back fields, stall and misalign)
//                slave  : mem_wb_stage itself
//  Revision    : 1.0  initial release
// ============================================================================
interface mem_wb_stage_if;
    import mips_pkg::*;

    // EX/MEM side
    logic [c_DATA_W-1:0] ALUResultin;
    logic [c_DATA_W-1:0] Rdata2in;
    logic [c_REG_W-1:0]  EX_MEM_Rdest;
    logic                RegWritein;
    logic                BWin;
    logic                MemWritein;
    logic                MemReadin;
    logic                MemToRegin;

    // MEM/WB side
    logic [c_DATA_W-1:0] WBData;
    logic [c_REG_W-1:0]  MEM_WB_Rdest;
    logic                RegWriteout;
    logic                mem_stall;
    logic                misalign;

    modport master (
        output ALUResultin, Rdata2in, EX_MEM_Rdest,
        output RegWritein, BWin, MemWritein, MemReadin, MemToRegin,
        input  WBData, MEM_WB_Rdest, RegWriteout, mem_stall, misalign
    );

    modport slave (
        input  ALUResultin, Rdata2in, EX_MEM_Rdest,
        input  RegWritein, BWin, MemWritein, MemReadin, MemToRegin,
        output WBData, MEM_WB_Rdest, RegWriteout, mem_stall, misalign
    );
endinterface
`default_nettype wire

// File: rtl/mem_wb_stage_data_mem.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem
//  Description : Word-organised data memory, 2**ADDR_W x 32 bits.
//                Synchronous byte-enabled write, asynchronous read.
//                Contents are intentionally not reset.
//  Ports       : clk   - write clock
//                we    - write enable
//                be    - per-byte write enables (bit n -> bits 8n+7:8n)
//                addr  - word index for both read and write
//                wdata - write data
//                rdata - combinational read of mem[addr]
//  Revision    : 1.0  initial release
// ============================================================================
module data_mem
    import mips_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  wire logic                clk,
    input  wire logic                we,
    input  wire logic [3:0]          be,
    input  wire logic [ADDR_W-1:0]   addr,
    input  wire logic [c_DATA_W-1:0] wdata,
    output logic      [c_DATA_W-1:0] rdata
);

    logic [c_DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    r_mem[addr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    assign rdata = r_mem[addr];

endmodule
`default_nettype wire

// File: rtl/mem_wb_stage.sv
`default_nettype none
// ============================================================================
//  Module      : mem_wb_stage
//  Description : MEM stage plus MEM/WB pipeline register of a MIPS-style
//                pipeline. Data-memory accesses take WAIT_STATES+1 cycles;
//                mem_stall holds the upstream EX/MEM register meanwhile and
//                the MEM/WB register captures bubbles until completion.
//  Ports       : clk  - clock, all state on posedge
//                rst  - asynchronous active-high reset
//                bus  - mem_wb_stage_if.slave (EX/MEM inputs, WBData,
//                       MEM_WB_Rdest, RegWriteout, mem_stall, misalign)
//  Revision    : 1.0  initial release
// ============================================================================
module mem_wb_stage
    import mips_pkg::*;
#(
    parameter int WAIT_STATES = 2,
    parameter int ADDR_W      = 8
) (
    input  wire logic         clk,
    input  wire logic         rst,
    mem_wb_stage_if.slave     bus
);

    localparam int c_CNT_W = (WAIT_STATES > 3) ? $clog2(WAIT_STATES + 1) : 2;
    localparam logic [c_CNT_W-1:0] c_CNT_LOAD =
        c_CNT_W'((WAIT_STATES > 0) ? (WAIT_STATES - 1) : 0);

    mem_state_t          r_state, w_next_state;
    logic [c_CNT_W-1:0]  r_cnt, w_next_cnt;
    logic                w_stall;
    logic                w_access;
    logic [1:0]          w_lane;
    logic [ADDR_W-1:0]   w_word;
    logic                w_we;
    logic [3:0]          w_be;
    logic [c_DATA_W-1:0] w_wdata;
    logic [c_DATA_W-1:0] w_rdword;
    logic [c_DATA_W-1:0] w_readdata;
    logic                w_misalign;

    logic [c_DATA_W-1:0] r_wbdata;
    logic [c_REG_W-1:0]  r_rdest;
    logic                r_regwrite;
    logic                r_misalign;

    // Address bits above the memory depth are don't-care.
    logic w_unused_addr;
    assign w_unused_addr = ^bus.ALUResultin[c_DATA_W-1:ADDR_W+2];

    assign w_access = bus.MemReadin | bus.MemWritein;
    assign w_lane   = bus.ALUResultin[1:0];
    assign w_word   = bus.ALUResultin[ADDR_W+1:2];

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
        end
    end

    // An access completes on the first edge where w_stall is low; with
    // WAIT_STATES == 0 the FSM never leaves IDLE.
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_stall      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_access && (WAIT_STATES > 0)) begin
                    w_stall      = 1'b1;
                    w_next_state = S_WAIT;
                    w_next_cnt   = c_CNT_LOAD;
                end
            end
            S_WAIT: begin
                if (r_cnt != '0) begin
                    w_stall    = 1'b1;
                    w_next_cnt = r_cnt - 1'b1;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------- memory
    // Writes land only on the completing edge; gating with rst keeps an
    // access interrupted by reset from touching the array.
    assign w_we    = bus.MemWritein & ~w_stall & ~rst;
    assign w_be    = bus.BWin ? (4'b0001 << w_lane) : 4'b1111;
    assign w_wdata = bus.BWin ? {4{bus.Rdata2in[7:0]}} : bus.Rdata2in;

    data_mem #(
        .ADDR_W (ADDR_W)
    ) u_data_mem (
        .clk   (clk),
        .we    (w_we),
        .be    (w_be),
        .addr  (w_word),
        .wdata (w_wdata),
        .rdata (w_rdword)
    );

    // A combined read+write performs only the write, so no read data.
    assign w_readdata = bus.MemWritein ? '0 :
                        bus.BWin       ? sext_byte(w_rdword, w_lane) :
                                         w_rdword;

    assign w_misalign = w_access & ~bus.BWin & (w_lane != 2'b00);

    // ------------------------------------------------------ MEM/WB register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wbdata   <= '0;
            r_rdest    <= '0;
            r_regwrite <= 1'b0;
            r_misalign <= 1'b0;
        end else if (w_stall) begin
            r_wbdata   <= '0;
            r_rdest    <= '0;
            r_regwrite <= 1'b0;
            r_misalign <= 1'b0;
        end else begin
            r_wbdata   <= bus.MemToRegin ? w_readdata : bus.ALUResultin;
            r_rdest    <= bus.EX_MEM_Rdest;
            r_regwrite <= bus.RegWritein & ~(bus.MemReadin & bus.MemWritein);
            r_misalign <= w_misalign;
        end
    end

    assign bus.WBData       = r_wbdata;
    assign bus.MEM_WB_Rdest = r_rdest;
    assign bus.RegWriteout  = r_regwrite;
    assign bus.misalign     = r_misalign;
    assign bus.mem_stall    = w_stall & ~rst;

endmodule
`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_wb_stage
//  Description : Directed self-checking bench for mem_wb_stage
//                (WAIT_STATES=2, ADDR_W=8). Expected write-back results are
//                derived from a bench-side memory model and queued when each
//                operation is driven, then popped at its completing edge.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_wb_stage;

    localparam int WS = 2;

    logic clk;
    logic rst;

    mem_wb_stage_if bus ();

    mem_wb_stage #(
        .WAIT_STATES (WS),
        .ADDR_W      (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] wb;
        logic [4:0]  rd;
        logic        rw;
        logic        mis;
        int          stalls;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] model [0:255];
    int          errors = 0;
    int          checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic drive(input logic rd_, input logic wr_, input logic bw_,
                         input logic m2r, input logic rw_,
                         input logic [31:0] alu, input logic [31:0] data,
                         input logic [4:0] rdest);
        bus.MemReadin    = rd_;
        bus.MemWritein   = wr_;
        bus.BWin         = bw_;
        bus.MemToRegin   = m2r;
        bus.RegWritein   = rw_;
        bus.ALUResultin  = alu;
        bus.Rdata2in     = data;
        bus.EX_MEM_Rdest = rdest;
    endtask

    // Drive one operation at a negedge, predict its result from the model,
    // follow it through its stall cycles and compare at the completing edge.
    task automatic op(input string tag, input logic rd_, input logic wr_,
                      input logic bw_, input logic m2r, input logic rw_,
                      input logic [31:0] alu, input logic [31:0] data,
                      input logic [4:0] rdest);
        exp_t        e;
        exp_t        got;
        logic [7:0]  idx;
        logic [1:0]  lane;
        logic [7:0]  b;
        logic [31:0] rdval;
        int          n;
        idx  = alu[9:2];
        lane = alu[1:0];
        if (wr_) begin
            if (bw_) model[idx][8*lane +: 8] = data[7:0];
            else     model[idx] = data;
        end
        b     = model[idx][8*lane +: 8];
        rdval = bw_ ? {{24{b[7]}}, b} : model[idx];
        e.wb     = m2r ? rdval : alu;
        e.rd     = rdest;
        e.rw     = rw_ & ~(rd_ & wr_);
        e.mis    = (rd_ | wr_) & ~bw_ & (lane != 2'b00);
        e.stalls = (rd_ | wr_) ? WS : 0;
        sb_q.push_back(e);

        drive(rd_, wr_, bw_, m2r, rw_, alu, data, rdest);
        #1;
        n = 0;
        while (bus.mem_stall === 1'b1 && n < 20) begin
            @(posedge clk); #1;
            check({tag, "_bubble_wb"}, bus.WBData, 32'h0);
            check({tag, "_bubble_rw"}, {31'b0, bus.RegWriteout}, 32'h0);
            n++;
            @(negedge clk); #1;
        end
        got = sb_q.pop_front();
        check({tag, "_stall_cycles"}, n, got.stalls);
        @(posedge clk); #1;
        check({tag, "_wbdata"},   bus.WBData, got.wb);
        check({tag, "_rdest"},    {27'b0, bus.MEM_WB_Rdest}, {27'b0, got.rd});
        check({tag, "_regwrite"}, {31'b0, bus.RegWriteout}, {31'b0, got.rw});
        check({tag, "_misalign"}, {31'b0, bus.misalign}, {31'b0, got.mis});
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_wbdata",   bus.WBData, 32'h0);
        check("rst_rdest",    {27'b0, bus.MEM_WB_Rdest}, 32'h0);
        check("rst_regwrite", {31'b0, bus.RegWriteout}, 32'h0);
        check("rst_misalign", {31'b0, bus.misalign}, 32'h0);
        drive(1, 0, 0, 1, 1, 32'h10, 32'h0, 5'd1);
        #1;
        check("rst_stall_low", {31'b0, bus.mem_stall}, 32'h0);
        drive(0, 0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
        @(negedge clk);
        rst = 1'b0;

        //  tag       rd wr bw m2r rw  alu           data           rdest
        op("sw10",    0, 1, 0, 0,  0,  32'h10,       32'h12345678,  5'd2);
        op("lw10",    1, 0, 0, 1,  1,  32'h10,       32'h0,         5'd3);
        op("sw20",    0, 1, 0, 0,  0,  32'h20,       32'h0,         5'd0);
        op("sb21",    0, 1, 1, 0,  0,  32'h21,       32'hFFFFFF80,  5'd0);
        op("lb21",    1, 0, 1, 1,  1,  32'h21,       32'h0,         5'd4);
        op("lw20",    1, 0, 0, 1,  1,  32'h20,       32'h0,         5'd5);
        op("alu",     0, 0, 0, 0,  1,  32'hDEAD,     32'h0,         5'd7);
        op("rdwr30",  1, 1, 0, 0,  1,  32'h30,       32'hAA,        5'd6);
        op("lw30",    1, 0, 0, 1,  1,  32'h30,       32'h0,         5'd8);
        op("sw40",    0, 1, 0, 0,  0,  32'h40,       32'h11111111,  5'd9);

        // Reset in the middle of a store's wait states: the store must be lost.
        drive(0, 1, 0, 0, 0, 32'h40, 32'h55, 5'd10);
        @(posedge clk); #2;
        check("abort_stall_in_wait", {31'b0, bus.mem_stall}, 32'h1);
        rst = 1'b1;
        #1;
        check("abort_stall",    {31'b0, bus.mem_stall}, 32'h0);
        check("abort_wbdata",   bus.WBData, 32'h0);
        check("abort_rdest",    {27'b0, bus.MEM_WB_Rdest}, 32'h0);
        check("abort_regwrite", {31'b0, bus.RegWriteout}, 32'h0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
        rst = 1'b0;
        op("idle_after_rst", 0, 0, 0, 0, 0, 32'h0, 32'h0, 5'd0);

        op("lw40",    1, 0, 0, 1,  1,  32'h40,       32'h0,         5'd11);
        op("lw13",    1, 0, 0, 1,  1,  32'h13,       32'h0,         5'd12);
        op("nop",     0, 0, 0, 0,  0,  32'h0,        32'h0,         5'd0);
        op("lb12",    1, 0, 1, 1,  1,  32'h12,       32'h0,         5'd13);
        op("lb13",    1, 0, 1, 1,  1,  32'h13,       32'h0,         5'd14);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 SHALL have parameter WAIT_STATES, default 2: extra cycles per data-memory access (0 = single-cycle).
REQ-002 SHALL have parameter ADDR_W, default 8: log2 of data-memory depth in 32-bit words.
REQ-003 SHALL have port clk, input, 1: single clock, all state on posedge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have ports ALUResultin, input, 32 (address or ALU result) and Rdata2in, input, 32 (store data).
REQ-006 SHALL have port EX_MEM_Rdest, input, 5: destination register.
REQ-007 SHALL have ports RegWritein, BWin, MemWritein, MemReadin, MemToRegin, input, 1 each: EX/MEM control.
REQ-008 SHALL have port WBData, output, 32: registered write-back value.
REQ-009 SHALL have ports MEM_WB_Rdest, output, 5 and RegWriteout, output, 1: registered write-back target/enable.
REQ-010 SHALL have port mem_stall, output, 1: combinational; upstream holds EX/MEM contents while high.
REQ-011 SHALL have port misalign, output, 1: registered one-cycle flag for a misaligned word access.

Function
REQ-012 Access = MemReadin | MemWritein; word index = ALUResultin[ADDR_W+1:2]; byte lane = ALUResultin[1:0].
REQ-013 FSM states IDLE, WAIT; 2-bit-or-wider down-counter cnt.
REQ-014 IDLE, access, WAIT_STATES>0: mem_stall=1, next WAIT, cnt<=WAIT_STATES-1.
REQ-015 WAIT: mem_stall=(cnt!=0); cnt decrements; cnt==0: access completes this edge, next IDLE.
REQ-016 IDLE with no access, or WAIT_STATES==0: mem_stall=0, access completes same edge; total access latency WAIT_STATES+1 cycles.
REQ-017 Word write (BWin=0): full Rdata2in written to word index at completing edge only.
REQ-018 Byte write (BWin=1): Rdata2in[7:0] into selected lane, other lanes unchanged.
REQ-019 Word read returns the addressed word; byte read returns selected lane sign-extended to 32 bits.
REQ-020 Word access with lane!=0: low bits ignored (aligned down), misalign=1 in the cycle after completion.
REQ-021 MemReadin and MemWritein both high: write performed, no read, RegWriteout forced 0 for that entry.
REQ-022 On completing (or non-memory) edge: WBData<=MemToRegin ? readdata : ALUResultin; MEM_WB_Rdest<=EX_MEM_Rdest; RegWriteout<=RegWritein.
REQ-023 Any edge with mem_stall=1: MEM/WB captures bubble (RegWriteout=0, WBData=0, MEM_WB_Rdest=0); no memory write.
REQ-024 Read data from a write in the immediately preceding completed access SHALL be the new value (no read-after-write hazard).

Reset
REQ-025 rst high asynchronously forces state IDLE, cnt=0, WBData=0, MEM_WB_Rdest=0, RegWriteout=0, misalign=0.
REQ-026 Reset mid-WAIT abandons the access: no memory write occurs; memory contents are not cleared by reset.
REQ-027 mem_stall SHALL be 0 while rst is high.

Structure
REQ-028 Package mips_pkg SHALL hold the FSM state enum, data width 32, and register-index width 5.
REQ-029 Sub-module data_mem SHALL hold the array: synchronous byte-enabled write, asynchronous read, parameter ADDR_W.
REQ-030 Top level SHALL contain only FSM, counter, lane select/extend, and the MEM/WB register.

Verification
REQ-031 WAIT_STATES=2: sw 0x12345678 @0x10, then lw @0x10, MemToReg=1 -> mem_stall high 2 cycles each, WBData=0x12345678 on 3rd cycle edge.
REQ-032 sb 0x80 @0x21 over word 0 -> lb @0x21 gives WBData=0xFFFFFF80; lw @0x20 gives 0x00008000.
REQ-033 Non-memory op RegWrite=1, ALU=0xDEAD, Rdest=7 -> next edge WBData=0xDEAD, MEM_WB_Rdest=7, RegWriteout=1, no stall.
REQ-034 Read+write both high, sw 0xAA @0x30 -> word updated to 0xAA, RegWriteout=0.
REQ-035 rst pulsed during WAIT of sw 0x55 @0x40 -> state IDLE, outputs 0, word @0x40 unchanged.
REQ-036 lw @0x13 (BW=0) -> data from 0x10, misalign=1 for exactly one cycle.
